block_stream_gen: RTL and testbench

- Transmitter side of the begin/end block-checking character stream.
- Accepts token commands (BEGIN, END, WORD, SPACE) and serializes them as 8-bit ASCII characters, one per accepted output beat.
- Tracks nesting depth and reports whether the emitted stream is balanced.
- Used to drive the block-checker receiver, and as a stimulus source for it, in P1 benches.

---
 rtl/block_stream_gen.sv | 183 ++++++++++++++++++
 tb/tb_block_stream_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/block_stream_gen.sv
// Begin/end block-checking stream transmitter: serializes BEGIN/END/WORD/SPACE
// tokens into ASCII characters and tracks nesting depth and stream balance.
module block_stream_gen #(
    parameter bit              UPPER     = 1'b0,
    parameter logic [7:0]      FILL_CHAR = 8'h78,
    parameter int unsigned     DEPTH_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic [3:0]         cmd_len,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               underflow,
    output logic               overflow,
    output logic               balanced
);

    localparam int unsigned IDX_W = 5;
    localparam logic [7:0]  SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {
        TOK_BEGIN = 2'b00,
        TOK_END   = 2'b01,
        TOK_WORD  = 2'b10,
        TOK_SPACE = 2'b11
    } tok_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    tok_e               tok_q, tok_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         len_q, len_d;
    logic [7:0]         out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               underflow_q, underflow_d;
    logic               overflow_q, overflow_d;
    logic               balanced_q, balanced_d;

    // Character at position i of token t; keyword letters optionally uppercased.
    function automatic logic [7:0] char_at(input tok_e t, input logic [IDX_W-1:0] i,
                                           input logic [3:0] l);
        logic [7:0] c;
        c = SPACE_CHAR;
        case (t)
            TOK_BEGIN: begin
                case (i)
                    5'd0:    c = 8'h62;
                    5'd1:    c = 8'h65;
                    5'd2:    c = 8'h67;
                    5'd3:    c = 8'h69;
                    5'd4:    c = 8'h6E;
                    default: c = SPACE_CHAR;
                endcase
            end
            TOK_END: begin
                case (i)
                    5'd0:    c = 8'h65;
                    5'd1:    c = 8'h6E;
                    5'd2:    c = 8'h64;
                    default: c = SPACE_CHAR;
                endcase
            end
            TOK_WORD: begin
                if (i < IDX_W'(l)) c = FILL_CHAR;
            end
            default: c = SPACE_CHAR;
        endcase
        if (UPPER && (t == TOK_BEGIN || t == TOK_END) && c != SPACE_CHAR)
            c = c & 8'hDF;
        return c;
    endfunction

    // Index of the trailing space for token t.
    function automatic logic [IDX_W-1:0] last_idx(input tok_e t, input logic [3:0] l);
        logic [IDX_W-1:0] r;
        case (t)
            TOK_BEGIN: r = 5'd5;
            TOK_END:   r = 5'd3;
            TOK_WORD:  r = IDX_W'(l);
            default:   r = 5'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        tok_d       = tok_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cmd_ready_d = cmd_ready_q;
        depth_d     = depth_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tok_d       = tok_e'(cmd);
                    len_d       = (cmd_len == 4'd0) ? 4'd1 : cmd_len;
                    idx_d       = '0;
                    state_d     = S_EMIT;
                    out_d       = char_at(tok_d, '0, len_d);
                    out_valid_d = 1'b1;
                    cmd_ready_d = 1'b0;
                    // Depth saturates; the token is still emitted.
                    if (tok_d == TOK_BEGIN) begin
                        if (depth_q == {DEPTH_W{1'b1}}) overflow_d = 1'b1;
                        else depth_d = depth_q + DEPTH_W'(1);
                    end else if (tok_d == TOK_END) begin
                        if (depth_q == '0) underflow_d = 1'b1;
                        else depth_d = depth_q - DEPTH_W'(1);
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    if (idx_q == last_idx(tok_q, len_q)) begin
                        state_d     = S_IDLE;
                        idx_d       = '0;
                        out_d       = SPACE_CHAR;
                        out_valid_d = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        out_d = char_at(tok_q, idx_d, len_q);
                    end
                end
            end
        endcase

        balanced_d = (depth_d == '0) && !underflow_d && !overflow_d && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tok_q       <= TOK_SPACE;
            idx_q       <= '0;
            len_q       <= 4'd1;
            out_q       <= SPACE_CHAR;
            out_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            depth_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            balanced_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            tok_q       <= tok_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cmd_ready_q <= cmd_ready_d;
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            balanced_q  <= balanced_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign balanced  = balanced_q;

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen: a lowercase/wide-depth instance and an
// uppercase/2-bit-depth instance driven by the same stimulus.
module tb_block_stream_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] cmd_len;
    logic       out_ready;

    logic       cmd_ready0, out_valid0, underflow0, overflow0, balanced0;
    logic [7:0] out0;
    logic [7:0] depth0;
    logic       cmd_ready1, out_valid1, underflow1, overflow1, balanced1;
    logic [7:0] out1;
    logic [1:0] depth1;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] C_BEGIN = 2'b00;
    localparam logic [1:0] C_END   = 2'b01;
    localparam logic [1:0] C_WORD  = 2'b10;

    always #5 clk = ~clk;

    block_stream_gen #(.UPPER(1'b0), .FILL_CHAR(8'h78), .DEPTH_W(8)) u_lo (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready0), .out(out0), .out_valid(out_valid0), .out_ready(out_ready),
        .depth(depth0), .underflow(underflow0), .overflow(overflow0), .balanced(balanced0)
    );

    block_stream_gen #(.UPPER(1'b1), .FILL_CHAR(8'h78), .DEPTH_W(2)) u_up (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready1), .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
        .depth(depth1), .underflow(underflow1), .overflow(overflow1), .balanced(balanced1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    // Consume the remaining characters of a token with out_ready held high.
    task automatic expect_tok(input string tag, input string lo, input string up);
        out_ready = 1'b1;
        for (int i = 0; i < lo.len(); i++) begin
            chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
            chk({tag, "_char_lo"}, 32'(out0), 32'(lo[i]));
            chk({tag, "_char_up"}, 32'(out1), 32'(up[i]));
            chk({tag, "_busy"}, 32'(cmd_ready0), 32'd0);
            step();
        end
        chk({tag, "_idle_valid"}, 32'(out_valid0), 32'd0);
        chk({tag, "_idle_ready"}, 32'(cmd_ready0), 32'd1);
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        cmd_len   = 4'd0;
        out_ready = 1'b1;
        do_reset();

        chk("rst_out", 32'(out0), 32'h20);
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_ready", 32'(cmd_ready0), 32'd1);
        chk("rst_depth", 32'(depth0), 32'd0);
        chk("rst_flags", 32'({underflow0, overflow0}), 32'd0);
        chk("rst_bal", 32'(balanced0), 32'd1);

        // BEGIN then END
        issue(C_BEGIN, 4'd0);
        chk("be_depth1", 32'(depth0), 32'd1);
        chk("be_bal0", 32'(balanced0), 32'd0);
        expect_tok("begin", "begin ", "BEGIN ");
        chk("be_bal_mid", 32'(balanced0), 32'd0);
        issue(C_END, 4'd0);
        chk("be_depth0", 32'(depth0), 32'd0);
        expect_tok("end", "end ", "END ");
        chk("be_bal1", 32'(balanced0), 32'd1);

        // WORD len 3 then len 0
        issue(C_WORD, 4'd3);
        expect_tok("word3", "xxx ", "xxx ");
        issue(C_WORD, 4'd0);
        expect_tok("word0", "x ", "x ");
        chk("word_depth", 32'(depth0), 32'd0);

        // Backpressure while "g" is shown; a command pulse during EMIT is dropped
        issue(C_BEGIN, 4'd0);
        chk("bp_b", 32'(out0), 32'h62);
        step();
        chk("bp_e", 32'(out0), 32'h65);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_g", 32'(out0), 32'h67);
            chk("bp_hold_valid", 32'(out_valid0), 32'd1);
            if (i == 1) begin
                cmd_valid = 1'b1;
                cmd       = C_END;
            end
            step();
            cmd_valid = 1'b0;
        end
        expect_tok("bp_rest", "gin ", "GIN ");
        chk("bp_depth_kept", 32'(depth0), 32'd1);
        issue(C_END, 4'd0);
        expect_tok("bp_end", "end ", "END ");
        chk("bp_bal", 32'(balanced0), 32'd1);

        // Overflow on the 2-bit-depth instance
        for (int i = 0; i < 3; i++) begin
            issue(C_BEGIN, 4'd0);
            expect_tok("ovf_begin", "begin ", "BEGIN ");
        end
        chk("ovf_depth3", 32'(depth1), 32'd3);
        chk("ovf_flag0", 32'(overflow1), 32'd0);
        issue(C_BEGIN, 4'd0);
        chk("ovf_depth_hold", 32'(depth1), 32'd3);
        chk("ovf_flag1", 32'(overflow1), 32'd1);
        chk("ovf_lo_depth4", 32'(depth0), 32'd4);
        chk("ovf_lo_flag", 32'(overflow0), 32'd0);
        expect_tok("ovf_begin4", "begin ", "BEGIN ");
        chk("ovf_bal", 32'(balanced1), 32'd0);

        // Underflow is sticky until reset
        do_reset();
        issue(C_END, 4'd0);
        expect_tok("unf_end", "end ", "END ");
        chk("unf_depth", 32'(depth0), 32'd0);
        chk("unf_flag", 32'(underflow0), 32'd1);
        chk("unf_bal", 32'(balanced0), 32'd0);
        issue(C_BEGIN, 4'd0);
        expect_tok("unf_b", "begin ", "BEGIN ");
        issue(C_END, 4'd0);
        expect_tok("unf_e", "end ", "END ");
        chk("unf_sticky", 32'(balanced0), 32'd0);
        do_reset();
        chk("unf_rst_bal", 32'(balanced0), 32'd1);
        chk("unf_rst_flag", 32'(underflow0), 32'd0);

        // Reset while "n" of BEGIN is shown
        issue(C_BEGIN, 4'd0);
        for (int i = 0; i < 4; i++) step();
        chk("rmid_n", 32'(out0), 32'h6E);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_valid", 32'(out_valid0), 32'd0);
        chk("rmid_depth", 32'(depth0), 32'd0);
        chk("rmid_ready", 32'(cmd_ready0), 32'd1);
        issue(C_BEGIN, 4'd0);
        expect_tok("rmid_next", "begin ", "BEGIN ");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
